// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and types for the registered N-way mux
// Purpose: default out-of-range output value, output-stage state enum,
//          and the legal range of the input count.
// Ports:   none (package).
package mux_pkg;

  localparam int unsigned DEFAULT_VAL_C = 66;
  localparam int unsigned N_IN_MIN      = 2;
  localparam int unsigned N_IN_MAX      = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/mux_n_sel.sv
// rtl/mux_n_sel.sv - combinational N-way select with out-of-range default
// Purpose: picks one WIDTH-bit slice of a packed input vector; selects at or
//          beyond N_IN return DEFAULT_VAL and raise out_of_range.
// Ports:   in_data      packed inputs, slice 0 = input A
//          sel          select value
//          out_data     selected slice or DEFAULT_VAL
//          out_of_range high when sel >= N_IN
module mux_n_sel import mux_pkg::*; #(
  parameter int unsigned        WIDTH       = 64,
  parameter int unsigned        N_IN        = 4,
  parameter int unsigned        SEL_W       = 3,
  parameter logic [WIDTH-1:0]   DEFAULT_VAL = WIDTH'(DEFAULT_VAL_C)
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_of_range
);

  // Start from the out-of-range result; a matching index overrides it.
  always_comb begin
    out_data     = DEFAULT_VAL;
    out_of_range = 1'b1;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (sel == SEL_W'(i)) begin
        out_data     = in_data[i*WIDTH +: WIDTH];
        out_of_range = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_reg_n.sv
// rtl/mux_reg_n.sv - registered N-way mux with valid/ready handshake
// Purpose: selects one of N_IN inputs through a loadable select register,
//          registers the result in a one-entry output stage, and flags
//          transfers that used an out-of-range select.
// Ports:   clk, reset_n            clock, async active-low reset
//          sel, sel_load           new select value and its load strobe
//          in_data, in_valid       packed inputs and their valid
//          in_ready                transfer accepted this cycle
//          out_data, out_valid     registered result and its valid
//          out_ready               downstream consumes out_data
//          sel_cur                 select register contents
//          sel_err, err_clr        sticky out-of-range flag and its clear
module mux_reg_n import mux_pkg::*; #(
  parameter int unsigned        WIDTH       = 64,
  parameter int unsigned        N_IN        = 4,
  parameter int unsigned        SEL_W       = 3,
  parameter logic [WIDTH-1:0]   DEFAULT_VAL = WIDTH'(DEFAULT_VAL_C)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_load,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      sel_cur,
  output logic                  sel_err,
  input  logic                  err_clr
);

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("mux_reg_n: N_IN out of legal range");
  end
  if (SEL_W < $clog2(N_IN)) begin : g_bad_sel_w
    $error("mux_reg_n: SEL_W too narrow for N_IN");
  end

  out_state_e         state, state_next;
  logic [SEL_W-1:0]   eff_sel;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_oor;
  logic               xfer;

  // A select presented with sel_load takes effect in the same cycle.
  assign eff_sel  = sel_load ? sel : sel_cur;
  assign in_ready = (state == EMPTY) || out_ready;
  assign xfer     = in_valid && in_ready;
  assign out_valid = (state == FULL);

  mux_n_sel #(
    .WIDTH       (WIDTH),
    .N_IN        (N_IN),
    .SEL_W       (SEL_W),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_sel (
    .in_data      (in_data),
    .sel          (eff_sel),
    .out_data     (sel_data),
    .out_of_range (sel_oor)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (xfer) state_next = FULL;
      FULL:  if (out_ready && !xfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= '0;
      sel_cur  <= '0;
      sel_err  <= 1'b0;
    end else begin
      if (sel_load) sel_cur <= sel;
      if (xfer) out_data <= sel_data;
      // A set in the same cycle as a clear wins.
      if (xfer && sel_oor) begin
        sel_err <= 1'b1;
      end else if (err_clr) begin
        sel_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_reg_n.sv
// tb/tb_mux_reg_n.sv - directed self-checking bench for mux_reg_n
module tb_mux_reg_n;

  logic         clk = 1'b0;
  logic         reset_n;

  logic [2:0]   sel;
  logic         sel_load;
  logic [255:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   sel_cur;
  logic         sel_err;
  logic         err_clr;

  logic [2:0]   sel8;
  logic         sel_load8;
  logic [255:0] in_data8;
  logic         in_valid8;
  logic         in_ready8;
  logic [31:0]  out_data8;
  logic         out_valid8;
  logic         out_ready8;
  logic [2:0]   sel_cur8;
  logic         sel_err8;
  logic         err_clr8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_reg_n u_dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .sel_load(sel_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_cur(sel_cur), .sel_err(sel_err), .err_clr(err_clr)
  );

  mux_reg_n #(.WIDTH(32), .N_IN(8), .SEL_W(3)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .sel(sel8), .sel_load(sel_load8),
    .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sel_cur(sel_cur8), .sel_err(sel_err8), .err_clr(err_clr8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] exp_q[$];
    logic [63:0] v;

    reset_n = 1'b0;
    sel = '0; sel_load = 0; in_data = '0; in_valid = 0; out_ready = 0; err_clr = 0;
    sel8 = '0; sel_load8 = 0; in_data8 = '0; in_valid8 = 0; out_ready8 = 0; err_clr8 = 0;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_sel_cur", 64'(sel_cur), 64'd0);
    check("rst_sel_err", 64'(sel_err), 64'd0);
    step(); step();
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic select with same-cycle bypass
    @(negedge clk);
    in_data = {64'd4, 64'd3, 64'd2, 64'd1};
    sel = 3'd2; sel_load = 1; in_valid = 1; out_ready = 1;
    step();
    check("basic_out_data", out_data, 64'd3);
    check("basic_out_valid", 64'(out_valid), 64'd1);
    check("basic_sel_cur", 64'(sel_cur), 64'd2);
    sel_load = 0; in_valid = 0;
    step();
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_out_data_hold", out_data, 64'd3);

    // Out-of-range select and sticky error
    sel = 3'd5; sel_load = 1; in_valid = 1;
    step();
    check("oor_out_data", out_data, 64'd66);
    check("oor_sel_err", 64'(sel_err), 64'd1);
    sel_load = 0; in_valid = 0; err_clr = 1;
    step();
    check("clr_sel_err", 64'(sel_err), 64'd0);
    err_clr = 0;
    step();
    check("oor_no_xfer_sel_err", 64'(sel_err), 64'd0);
    in_valid = 1; err_clr = 1;
    step();
    check("set_clr_sel_err", 64'(sel_err), 64'd1);
    check("set_clr_out_data", out_data, 64'd66);
    in_valid = 0;
    step();
    check("clr2_sel_err", 64'(sel_err), 64'd0);
    err_clr = 0;

    // Backpressure hold
    in_data = {64'd40, 64'd30, 64'd20, 64'd10};
    sel = 3'd1; sel_load = 1; in_valid = 1; out_ready = 1;
    step();
    check("bp_load_out_data", out_data, 64'd20);
    sel_load = 0; out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_data = {64'd100 + 64'(k), 64'd200 + 64'(k), 64'd300 + 64'(k), 64'd400 + 64'(k)};
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      step();
      check("bp_out_data", out_data, 64'd20);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_data = {64'd44, 64'd33, 64'd77, 64'd11};
    out_ready = 1;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    step();
    check("bp_release_out_data", out_data, 64'd77);
    check("bp_release_out_valid", 64'(out_valid), 64'd1);

    // Back-to-back stream, sel cycling 0..3
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) in_data[j*64 +: 64] = 64'(16 * k + j + 1);
      sel = 3'(k % 4); sel_load = 1; in_valid = 1; out_ready = 1;
      exp_q.push_back(64'(16 * k + (k % 4) + 1));
      step();
      v = exp_q.pop_front();
      check("stream_out_data", out_data, v);
      check("stream_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 0; sel_load = 0;
    step();
    check("stream_end_out_valid", 64'(out_valid), 64'd0);

    // Async reset between edges
    sel = 3'd6; sel_load = 1; in_valid = 1;
    step();
    check("pre_rst_sel_err", 64'(sel_err), 64'd1);
    sel = 3'd3;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_sel_cur", 64'(sel_cur), 64'd0);
    check("async_rst_sel_err", 64'(sel_err), 64'd0);
    check("async_rst_out_data", out_data, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    in_data = {64'd9, 64'd8, 64'd7, 64'd6};
    sel = 3'd1; sel_load = 1; in_valid = 1; out_ready = 1;
    step();
    check("post_rst_out_data", out_data, 64'd7);
    check("post_rst_out_valid", 64'(out_valid), 64'd1);
    in_valid = 0; sel_load = 0;

    // WIDTH=32, N_IN=8 instance: every select reaches its input
    for (int j = 0; j < 8; j++) in_data8[j*32 +: 32] = 32'h1000_0000 * 32'(j + 1) + 32'(j);
    out_ready8 = 1;
    for (int s = 0; s < 8; s++) begin
      sel8 = 3'(s); sel_load8 = 1; in_valid8 = 1;
      step();
      check("w32_out_data", 64'(out_data8), 64'(32'h1000_0000 * 32'(s + 1) + 32'(s)));
      check("w32_sel_err", 64'(sel_err8), 64'd0);
    end
    in_valid8 = 0; sel_load8 = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
